desrotador_palabras: RTL and testbench
======================================

Name: desrotador_palabras

Overview:
- Receive-side counterpart of the word rotator: accepts the rotated bus plus its one-hot control vector and error flag, and restores the original {head, payload, tail} frame.
- Checks every restored frame, tracks link state in a small FSM, counts good frames and flags faults.
- Sits directly downstream of the rotator (its data_out/control_out/error_out feed this block) and closes the loop for end-to-end benches.

Parameters:
- BUS_SIZE, 60, total bus width in bits.
- WORD_SIZE, 6, bits per word.
- WORD_NUM, BUS_SIZE/WORD_SIZE, words per bus (10).
- IDX_W, 4, width of word index/shift (ceil log2 WORD_NUM).
- CNT_W, 8, width of good-frame counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  BUS_SIZE  rotated bus from rotator.
- control_in  input  WORD_NUM  one-hot position of header word; all-zero means bubble.
- error_in  input  1  error flag from rotator.
- data_out  output  BUS_SIZE  restored frame {head, payload, tail}.
- valid_out  output  1  data_out holds a good frame.
- shift_out  output  IDX_W  rotation amount undone (0..WORD_NUM-1).
- error_out  output  1  current frame classified BAD.
- err_sticky  output  1  set on any BAD frame; cleared only by reset.
- frame_cnt  output  CNT_W  count of GOOD frames, saturating.
- state_out  output  2  FSM state (IDLE=0, ACTIVE=1, FAULT=2).

Behaviour:
- Word i = data bits [WORD_SIZE*(i+1)-1 : WORD_SIZE*i]. The header is word WORD_NUM-1, the tail is word 0.
- Rotator convention: input word i moves to word (i+tail) mod WORD_NUM. The header therefore lands at idx = (WORD_NUM-1+tail) mod WORD_NUM.
- Stage 1 (registered):
  - Capture data_in and error_in.
  - Decode control_in: onehot_ok = exactly one bit set; idx = position of that bit; bubble = (control_in==0) and (error_in==0).
  - Compute s = (idx+1) mod WORD_NUM.
- Stage 2 (registered outputs):
  - Rotate the stage-1 data right by s words.
  - Classify:
    - GOOD: onehot_ok, error_in=0, restored header word all ones, restored tail word == s.
    - BUBBLE: as decoded in stage 1.
    - BAD: everything else, including multi-hot control, or error_in=1 with any control.
- Latency: 2 clocks. Inputs sampled at edge t; outputs valid after edge t+1. Full throughput, one frame per cycle, no backpressure.
- Outputs per stage-2 class:
  - GOOD: data_out=restored, valid_out=1, shift_out=s, error_out=0, frame_cnt+1 (saturates at all-ones).
  - BUBBLE: data_out=0, valid_out=0, shift_out=0, error_out=0.
  - BAD: data_out=0, valid_out=0, shift_out=0, error_out=1, err_sticky<=1.
- FSM (updated with stage 2):
  - IDLE: GOOD->ACTIVE; BAD->FAULT; BUBBLE->IDLE.
  - ACTIVE: GOOD->ACTIVE; BUBBLE->IDLE; BAD->FAULT.
  - FAULT: GOOD->ACTIVE; BUBBLE->IDLE; BAD->FAULT.
  - Unused encoding 3 -> IDLE.
- Reset (async assert, any time, mid-frame included):
  - All pipeline registers and outputs go to 0; state=IDLE; frame_cnt=0; err_sticky=0.
  - In-flight frames are discarded.
  - First valid output occurs 2 edges after reset deasserts with GOOD input present.
- Boundaries:
  - tail=0 gives idx=9, s=0, data passes unrotated.
  - tail=9 gives idx=8, s=9.
  - An out-of-range tail (>=WORD_NUM) in the original frame yields a tail/s mismatch and is classified BAD.

Decomposition:
- Shared package holds:
  - bus/word/index width constants (BUS_SIZE, WORD_SIZE, WORD_NUM, IDX_W);
  - FSM state encodings IDLE/ACTIVE/FAULT;
  - frame class encodings GOOD/BUBBLE/BAD;
  - HEAD_MARK = all-ones word.
- One sub-module is natural: rotador_der_palabras, a combinational word-granular right rotate by s (WORD_NUM:1 mux per word), reusable by the bench model.

Test Plan:
- Reset low 5 time units, then frame head=6'h3F, tail=3, payload random, rotated left 3, control_in=10'b0000000100 -> 2 clocks later data_out equals original, shift_out=3, valid_out=1, state_out=1, frame_cnt=1.
- Three consecutive GOOD frames with tails 0,1,2 (control_in 10'b1000000000, 10'b0000000001, 10'b0000000010) -> shift_out 0,1,2 on back-to-back cycles, frame_cnt=3.
- control_in=10'b0000100100 (multi-hot) mid-stream -> error_out=1, data_out=0, state FAULT, err_sticky=1. The following GOOD frame returns state to ACTIVE with err_sticky still 1.
- Restored header 6'h15, or tail word 5 with s=4 -> classified BAD, error_out=1, frame_cnt unchanged.
- control_in=0, error_in=0 after ACTIVE -> state IDLE, valid_out=0, error_out=0. Drive 300 GOOD frames -> frame_cnt saturates at 255.
- Assert reset low between the two pipeline edges of an in-flight GOOD frame -> outputs immediately 0, frame never appears, state IDLE, frame_cnt=0.

Source files
------------

// File: rtl/desrotador_palabras_pkg.sv
// desrotador_palabras_pkg
// Shared constants and encodings for the word de-rotator.
//   BUS_SIZE / WORD_SIZE / WORD_NUM / IDX_W : bus geometry and index width
//   CNT_W                                   : good-frame counter width
//   state_t                                 : link FSM states (IDLE/ACTIVE/FAULT)
//   frame_class_t                           : per-frame classification (GOOD/BUBBLE/BAD)
//   HEAD_MARK                               : expected header word (all ones)
package desrotador_palabras_pkg;

    localparam int BUS_SIZE  = 60;
    localparam int WORD_SIZE = 6;
    localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GOOD   = 2'd0,
        BUBBLE = 2'd1,
        BAD    = 2'd2
    } frame_class_t;

    localparam logic [WORD_SIZE-1:0] HEAD_MARK = '1;

endpackage

// File: rtl/rotador_der_palabras.sv
// rotador_der_palabras
// Combinational word-granular right rotate: output word j takes input
// word (j + shift) mod WORD_NUM. This undoes a left rotation by `shift`.
//   data_in  [BUS_SIZE-1:0] : rotated bus
//   shift    [IDX_W-1:0]    : rotation to undo (0..WORD_NUM-1)
//   data_out [BUS_SIZE-1:0] : restored bus (words forced to 0 for shift >= WORD_NUM)
module rotador_der_palabras
    import desrotador_palabras_pkg::*;
(
    input  logic [BUS_SIZE-1:0] data_in,
    input  logic [IDX_W-1:0]    shift,
    output logic [BUS_SIZE-1:0] data_out
);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_NUM; gi++) begin : g_word
            logic [WORD_SIZE-1:0] word_sel;

            // One WORD_NUM:1 mux per output word.
            always_comb begin
                word_sel = '0;
                for (int k = 0; k < WORD_NUM; k++) begin
                    if (shift == IDX_W'(k)) begin
                        word_sel = data_in[((gi + k) % WORD_NUM) * WORD_SIZE +: WORD_SIZE];
                    end
                end
            end

            assign data_out[gi*WORD_SIZE +: WORD_SIZE] = word_sel;
        end
    endgenerate

endmodule

// File: rtl/desrotador_palabras.sv
// desrotador_palabras
// Receive-side word de-rotator. Two-stage pipeline:
//   stage 1 registers the bus and decodes the one-hot header position,
//   stage 2 rotates the frame back, classifies it and drives the outputs.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous, active-low reset
//   data_in    : rotated bus
//   control_in : one-hot header position, all-zero = bubble
//   error_in   : error flag from the rotator
//   data_out   : restored {head, payload, tail} (0 unless GOOD)
//   valid_out  : data_out holds a GOOD frame
//   shift_out  : rotation undone (0 unless GOOD)
//   error_out  : current frame is BAD
//   err_sticky : latched on any BAD frame until reset
//   frame_cnt  : saturating count of GOOD frames
//   state_out  : link FSM state
module desrotador_palabras
    import desrotador_palabras_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_SIZE-1:0] data_in,
    input  logic [WORD_NUM-1:0] control_in,
    input  logic                error_in,
    output logic [BUS_SIZE-1:0] data_out,
    output logic                valid_out,
    output logic [IDX_W-1:0]    shift_out,
    output logic                error_out,
    output logic                err_sticky,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [1:0]          state_out
);

    // ---------------- stage 1: decode ----------------
    logic [IDX_W:0]   ctl_ones;
    logic [IDX_W-1:0] idx_dec;
    logic [IDX_W-1:0] shift_dec;

    always_comb begin
        ctl_ones = '0;
        idx_dec  = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            if (control_in[i]) begin
                ctl_ones = ctl_ones + (IDX_W+1)'(1);
                idx_dec  = IDX_W'(i);
            end
        end
        // Header sits at (WORD_NUM-1+tail) mod WORD_NUM, so the rotation is idx+1 wrapped.
        shift_dec = (idx_dec == IDX_W'(WORD_NUM-1)) ? '0 : idx_dec + IDX_W'(1);
    end

    logic [BUS_SIZE-1:0] data_s1_reg;
    logic                err_s1_reg;
    logic                onehot_s1_reg;
    logic                ctl_any_s1_reg;
    logic [IDX_W-1:0]    shift_s1_reg;

    // The stage-1 flags are stored so that an all-zero register set decodes
    // as a bubble; the cycle right after reset then produces no spurious BAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_s1_reg    <= '0;
            err_s1_reg     <= 1'b0;
            onehot_s1_reg  <= 1'b0;
            ctl_any_s1_reg <= 1'b0;
            shift_s1_reg   <= '0;
        end else begin
            data_s1_reg    <= data_in;
            err_s1_reg     <= error_in;
            onehot_s1_reg  <= (ctl_ones == (IDX_W+1)'(1));
            ctl_any_s1_reg <= |control_in;
            shift_s1_reg   <= shift_dec;
        end
    end

    // ---------------- stage 2: restore and classify ----------------
    logic [BUS_SIZE-1:0]  restored;
    logic [WORD_SIZE-1:0] head_word;
    logic [WORD_SIZE-1:0] tail_word;

    rotador_der_palabras u_rot (
        .data_in  (data_s1_reg),
        .shift    (shift_s1_reg),
        .data_out (restored)
    );

    assign head_word = restored[BUS_SIZE-1 -: WORD_SIZE];
    assign tail_word = restored[WORD_SIZE-1:0];

    frame_class_t        frame_class;
    logic [BUS_SIZE-1:0] data_out_reg,  data_out_next;
    logic                valid_reg,     valid_next;
    logic [IDX_W-1:0]    shift_out_reg, shift_out_next;
    logic                error_reg,     error_next;
    logic                sticky_reg,    sticky_next;
    logic [CNT_W-1:0]    cnt_reg,       cnt_next;
    state_t              state_reg,     state_next;

    always_comb begin
        // Any error flag wins; otherwise an empty control vector is a bubble.
        if (err_s1_reg) begin
            frame_class = BAD;
        end else if (!ctl_any_s1_reg) begin
            frame_class = BUBBLE;
        end else if (onehot_s1_reg && (head_word == HEAD_MARK) &&
                     (tail_word == WORD_SIZE'(shift_s1_reg))) begin
            frame_class = GOOD;
        end else begin
            frame_class = BAD;
        end

        data_out_next  = '0;
        valid_next     = 1'b0;
        shift_out_next = '0;
        error_next     = 1'b0;
        sticky_next    = sticky_reg;
        cnt_next       = cnt_reg;

        case (frame_class)
            GOOD: begin
                data_out_next  = restored;
                valid_next     = 1'b1;
                shift_out_next = shift_s1_reg;
                if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            BAD: begin
                error_next  = 1'b1;
                sticky_next = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- link FSM ----------------
    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE, ACTIVE, FAULT: begin
                case (frame_class)
                    GOOD:    state_next = ACTIVE;
                    BAD:     state_next = FAULT;
                    default: state_next = IDLE;
                endcase
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_reg  <= '0;
            valid_reg     <= 1'b0;
            shift_out_reg <= '0;
            error_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
        end else begin
            data_out_reg  <= data_out_next;
            valid_reg     <= valid_next;
            shift_out_reg <= shift_out_next;
            error_reg     <= error_next;
            sticky_reg    <= sticky_next;
            cnt_reg       <= cnt_next;
            state_reg     <= state_next;
        end
    end

    assign data_out   = data_out_reg;
    assign valid_out  = valid_reg;
    assign shift_out  = shift_out_reg;
    assign error_out  = error_reg;
    assign err_sticky = sticky_reg;
    assign frame_cnt  = cnt_reg;
    assign state_out  = state_reg;

endmodule

// File: tb/tb_desrotador_palabras.sv
// tb_desrotador_palabras
// Directed bench for desrotador_palabras. Inputs change on the falling
// edge, outputs are sampled on the falling edge; a frame applied at one
// falling edge shows up at the output two falling edges later.
module tb_desrotador_palabras;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [59:0] data_in = '0;
    logic [9:0]  control_in = '0;
    logic        error_in = 1'b0;
    logic [59:0] data_out;
    logic        valid_out;
    logic [3:0]  shift_out;
    logic        error_out;
    logic        err_sticky;
    logic [7:0]  frame_cnt;
    logic [1:0]  state_out;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    desrotador_palabras dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .control_in (control_in),
        .error_in   (error_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .shift_out  (shift_out),
        .error_out  (error_out),
        .err_sticky (err_sticky),
        .frame_cnt  (frame_cnt),
        .state_out  (state_out)
    );

    // Rotator model: word i moves to word (i+t) mod 10.
    function automatic logic [59:0] rot_left(input logic [59:0] f, input int t);
        logic [59:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[((i + t) % 10) * 6 +: 6] = f[i*6 +: 6];
        return r;
    endfunction

    function automatic logic [59:0] mk_frame(input logic [5:0] head, input logic [5:0] tail);
        logic [47:0] pl;
        pl = {16'($urandom), 32'($urandom)};
        return {head, pl, tail};
    endfunction

    task automatic put(input logic [59:0] d, input logic [9:0] c, input logic e);
        data_in = d;
        control_in = c;
        error_in = e;
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #2;
        $display("txn reset: data=%h valid=%b shift=%0d err=%b sticky=%b cnt=%0d state=%0d",
                 data_out, valid_out, shift_out, error_out, err_sticky, frame_cnt, state_out);
        total++; if (data_out !== 60'd0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        total++; if (shift_out !== 4'd0) begin bad++; $display("FAIL reset_shift got=%0d want=0", shift_out); end
        total++; if (error_out !== 1'b0 || err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b want=0/0", error_out, err_sticky); end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", frame_cnt); end
        total++; if (state_out !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_out); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        logic [59:0] fr;
        fr = mk_frame(6'h3F, 6'd3);
        @(negedge clk); put(rot_left(fr, 3), 10'b0000000100, 1'b0);
        @(negedge clk); put('0, '0, 1'b0);
        @(negedge clk);
        exp_cnt = 1;
        $display("txn basic: data=%h shift=%0d valid=%b state=%0d cnt=%0d", data_out, shift_out, valid_out, state_out, frame_cnt);
        total++; if (data_out !== fr) begin bad++; $display("FAIL basic_data got=%h want=%h", data_out, fr); end
        total++; if (shift_out !== 4'd3) begin bad++; $display("FAIL basic_shift got=%0d want=3", shift_out); end
        total++; if (valid_out !== 1'b1 || error_out !== 1'b0) begin bad++; $display("FAIL basic_valid got=%b/%b want=1/0", valid_out, error_out); end
        total++; if (state_out !== 2'd1) begin bad++; $display("FAIL basic_state got=%0d want=1", state_out); end
        total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL basic_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
    endtask

    // Tails 0,1,2 and the 9 boundary, back to back.
    task automatic test_back_to_back;
        logic [59:0] fr[4];
        logic [9:0]  ct[4];
        int          tl[4];
        tl = '{0, 1, 2, 9};
        ct = '{10'b1000000000, 10'b0000000001, 10'b0000000010, 10'b0100000000};
        for (int k = 0; k < 4; k++) fr[k] = mk_frame(6'h3F, 6'(tl[k]));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_cnt++;
                $display("txn b2b tail=%0d: data=%h shift=%0d valid=%b cnt=%0d", tl[k-2], data_out, shift_out, valid_out, frame_cnt);
                total++; if (data_out !== fr[k-2]) begin bad++; $display("FAIL b2b_data got=%h want=%h", data_out, fr[k-2]); end
                total++; if (shift_out !== 4'(tl[k-2])) begin bad++; $display("FAIL b2b_shift got=%0d want=%0d", shift_out, tl[k-2]); end
                total++; if (valid_out !== 1'b1 || state_out !== 2'd1) begin bad++; $display("FAIL b2b_valid got=%b/%0d want=1/1", valid_out, state_out); end
                total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
            end
            if (k < 4) put(rot_left(fr[k], tl[k]), ct[k], 1'b0);
            else       put('0, '0, 1'b0);
        end
    endtask

    // GOOD, multi-hot BAD, GOOD: FAULT then back to ACTIVE with sticky kept.
    task automatic test_fault_recover;
        logic [59:0] f0, f1, f2;
        f0 = mk_frame(6'h3F, 6'd4);
        f1 = mk_frame(6'h3F, 6'd2);
        f2 = mk_frame(6'h3F, 6'd5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) begin
                exp_cnt++;
                $display("txn fault pre: valid=%b state=%0d sticky=%b", valid_out, state_out, err_sticky);
                total++; if (valid_out !== 1'b1 || err_sticky !== 1'b0 || data_out !== f0) begin bad++; $display("FAIL pre_good got=%b/%b want=1/0", valid_out, err_sticky); end
            end
            if (k == 3) begin
                $display("txn fault multihot: data=%h err=%b state=%0d sticky=%b cnt=%0d", data_out, error_out, state_out, err_sticky, frame_cnt);
                total++; if (error_out !== 1'b1) begin bad++; $display("FAIL mh_err got=%b want=1", error_out); end
                total++; if (data_out !== 60'd0 || valid_out !== 1'b0 || shift_out !== 4'd0) begin bad++; $display("FAIL mh_data got=%h/%b want=0/0", data_out, valid_out); end
                total++; if (state_out !== 2'd2) begin bad++; $display("FAIL mh_state got=%0d want=2", state_out); end
                total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL mh_sticky got=%b want=1", err_sticky); end
                total++; if (frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL mh_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
            end
            if (k == 4) begin
                exp_cnt++;
                $display("txn fault recover: valid=%b state=%0d sticky=%b", valid_out, state_out, err_sticky);
                total++; if (state_out !== 2'd1 || valid_out !== 1'b1 || error_out !== 1'b0) begin bad++; $display("FAIL rec_state got=%0d/%b want=1/1", state_out, valid_out); end
                total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL rec_sticky got=%b want=1", err_sticky); end
                total++; if (data_out !== f2 || shift_out !== 4'd5) begin bad++; $display("FAIL rec_data got=%h want=%h", data_out, f2); end
            end
            case (k)
                0:       put(rot_left(f0, 4), 10'b0000001000, 1'b0);
                1:       put(rot_left(f1, 2), 10'b0000100100, 1'b0);
                2:       put(rot_left(f2, 5), 10'b0000010000, 1'b0);
                default: put('0, '0, 1'b0);
            endcase
        end
    endtask

    // Bad header, tail/s mismatch, error_in set, out-of-range tail.
    task automatic test_bad_class;
        logic [59:0] di[4];
        logic [9:0]  ct[4];
        logic        er[4];
        di[0] = rot_left(mk_frame(6'h15, 6'd3), 3);  ct[0] = 10'b0000000100; er[0] = 1'b0;
        di[1] = rot_left(mk_frame(6'h3F, 6'd5), 4);  ct[1] = 10'b0000001000; er[1] = 1'b0;
        di[2] = rot_left(mk_frame(6'h3F, 6'd1), 1);  ct[2] = 10'b0000000001; er[2] = 1'b1;
        di[3] = rot_left(mk_frame(6'h3F, 6'd12), 2); ct[3] = 10'b0000000010; er[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                $display("txn bad case=%0d: data=%h valid=%b err=%b state=%0d cnt=%0d", k-2, data_out, valid_out, error_out, state_out, frame_cnt);
                total++; if (error_out !== 1'b1) begin bad++; $display("FAIL bad_err case=%0d got=%b want=1", k-2, error_out); end
                total++; if (data_out !== 60'd0 || valid_out !== 1'b0 || shift_out !== 4'd0) begin bad++; $display("FAIL bad_data case=%0d got=%h/%b want=0/0", k-2, data_out, valid_out); end
                total++; if (frame_cnt !== 8'(exp_cnt) || state_out !== 2'd2) begin bad++; $display("FAIL bad_cnt case=%0d got=%0d/%0d want=%0d/2", k-2, frame_cnt, state_out, exp_cnt); end
            end
            if (k < 4) put(di[k], ct[k], er[k]);
            else       put('0, '0, 1'b0);
        end
    endtask

    // GOOD then bubble (IDLE), then 300 GOOD frames to saturate the counter.
    task automatic test_bubble_saturate;
        logic [59:0] fr;
        int          tl;
        fr = mk_frame(6'h3F, 6'd6);
        @(negedge clk); put(rot_left(fr, 6), 10'b0000100000, 1'b0);
        @(negedge clk); put('0, '0, 1'b0);
        @(negedge clk); exp_cnt++;
        @(negedge clk);
        $display("txn bubble: data=%h valid=%b err=%b state=%0d", data_out, valid_out, error_out, state_out);
        total++; if (state_out !== 2'd0) begin bad++; $display("FAIL bubble_state got=%0d want=0", state_out); end
        total++; if (valid_out !== 1'b0 || error_out !== 1'b0 || data_out !== 60'd0) begin bad++; $display("FAIL bubble_out got=%b/%b want=0/0", valid_out, error_out); end
        for (int k = 0; k < 302; k++) begin
            if (k >= 2) begin
                if (exp_cnt < 255) exp_cnt++;
                total++; if (valid_out !== 1'b1 || frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL sat_step k=%0d got=%b/%0d want=1/%0d", k-2, valid_out, frame_cnt, exp_cnt); end
            end
            if (k < 300) begin
                tl = k % 10;
                fr = mk_frame(6'h3F, 6'(tl));
                put(rot_left(fr, tl), 10'(1) << ((9 + tl) % 10), 1'b0);
            end else begin
                put('0, '0, 1'b0);
            end
            @(negedge clk);
        end
        $display("txn saturate: cnt=%0d", frame_cnt);
        total++; if (frame_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", frame_cnt); end
    endtask

    // Reset between the two pipeline edges of a GOOD frame.
    task automatic test_reset_midflight;
        logic [59:0] fa, fb;
        fa = mk_frame(6'h3F, 6'd6);
        fb = mk_frame(6'h3F, 6'd7);
        @(negedge clk); put(rot_left(fa, 6), 10'b0000100000, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_cnt = 0;
        $display("txn midreset: data=%h valid=%b state=%0d cnt=%0d sticky=%b", data_out, valid_out, state_out, frame_cnt, err_sticky);
        total++; if (data_out !== 60'd0 || valid_out !== 1'b0 || shift_out !== 4'd0) begin bad++; $display("FAIL mid_out got=%h/%b want=0/0", data_out, valid_out); end
        total++; if (state_out !== 2'd0 || error_out !== 1'b0) begin bad++; $display("FAIL mid_state got=%0d want=0", state_out); end
        total++; if (frame_cnt !== 8'd0 || err_sticky !== 1'b0) begin bad++; $display("FAIL mid_cnt got=%0d/%b want=0/0", frame_cnt, err_sticky); end
        put('0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_ghost got=%b want=0", valid_out); end
        reset = 1'b1;
        put(rot_left(fb, 7), 10'b0001000000, 1'b0);
        @(negedge clk); 
        total++; if (valid_out !== 1'b0 || frame_cnt !== 8'd0) begin bad++; $display("FAIL mid_early got=%b/%0d want=0/0", valid_out, frame_cnt); end
        put('0, '0, 1'b0);
        @(negedge clk);
        exp_cnt = 1;
        $display("txn after reset: data=%h shift=%0d valid=%b cnt=%0d state=%0d", data_out, shift_out, valid_out, frame_cnt, state_out);
        total++; if (valid_out !== 1'b1 || data_out !== fb || shift_out !== 4'd7) begin bad++; $display("FAIL post_data got=%h want=%h", data_out, fb); end
        total++; if (frame_cnt !== 8'(exp_cnt) || state_out !== 2'd1) begin bad++; $display("FAIL post_cnt got=%0d/%0d want=1/1", frame_cnt, state_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fault_recover();
        test_bad_class();
        test_bubble_saturate();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
